// File: rtl/bcd_display_scanner_if.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner_if
// Groups the capture inputs, the live display controls and the multiplexed
// seven-segment outputs of bcd_display_scanner into one bundle.
//
//   load_i         capture strobe (converter done pulse)
//   BCD_i          packed BCD word, nibble k = digit k, digit 0 least significant
//   dp_i           decimal-point mask, captured together with BCD_i
//   blank_zeros_i  1 = suppress leading zeros (live)
//   enable_i       0 = display dark (live)
//   an_o           anode selects, active-low
//   seg_o          segments {g,f,e,d,c,b,a}, active-low
//   dp_o           decimal point, active-low
//
// master: the side that drives the word and controls (converter / bench).
// slave : the scanner itself.
// -----------------------------------------------------------------------------
interface bcd_display_scanner_if #(
   parameter int DIGITS = 4,
   parameter int BCD_N  = 4 * DIGITS
);
   logic              load_i;
   logic [BCD_N-1:0]  BCD_i;
   logic [DIGITS-1:0] dp_i;
   logic              blank_zeros_i;
   logic              enable_i;
   logic [DIGITS-1:0] an_o;
   logic [6:0]        seg_o;
   logic              dp_o;

   modport master (
      output load_i, BCD_i, dp_i, blank_zeros_i, enable_i,
      input  an_o, seg_o, dp_o
   );

   modport slave (
      input  load_i, BCD_i, dp_i, blank_zeros_i, enable_i,
      output an_o, seg_o, dp_o
   );
endinterface

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
// Captures a packed BCD word on a one-cycle load strobe and time-multiplexes it
// onto a common-anode multi-digit seven-segment display. Each digit is lit for
// REFRESH_DIV clock cycles; the scan never stops or restarts except on reset.
// Supports leading-zero blanking, a per-digit decimal-point mask and a global
// display enable. All display outputs are registered.
//
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  synchronous reset, active-high
//   bus      bcd_display_scanner_if.slave (word, controls, an/seg/dp outputs)
//
// BCD_N must equal 4*DIGITS.
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
   parameter int DIGITS      = 4,
   parameter int BCD_N       = 4 * DIGITS,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   bcd_display_scanner_if.slave   bus
);

   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // Active-low segment pattern for one BCD nibble; 10..15 render as a dash.
   function automatic logic [6:0] seg_code(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'd0:    code = 7'h40;
         4'd1:    code = 7'h79;
         4'd2:    code = 7'h24;
         4'd3:    code = 7'h30;
         4'd4:    code = 7'h19;
         4'd5:    code = 7'h12;
         4'd6:    code = 7'h02;
         4'd7:    code = 7'h78;
         4'd8:    code = 7'h00;
         4'd9:    code = 7'h10;
         default: code = 7'h3F;
      endcase
      return code;
   endfunction

   // Holding registers, scan state and registered outputs.
   logic [BCD_N-1:0]  held_bcd_q, held_bcd_d;
   logic [DIGITS-1:0] held_dp_q,  held_dp_d;
   logic [PRE_W-1:0]  pre_q,      pre_d;
   logic [IDX_W-1:0]  idx_q,      idx_d;
   logic [DIGITS-1:0] an_q,       an_d;
   logic [6:0]        seg_q,      seg_d;
   logic              dp_q,       dp_d;

   // blank_mask[k] = digit k is a leading zero of the held word.
   logic [DIGITS-1:0] blank_mask;
   logic              zero_above;
   logic [3:0]        nib;

   // Capture and scan next-state.
   // NOTE: every signal driven from always_comb gets a default at the top so
   // that no path leaves it unassigned; otherwise a latch is inferred.
   always_comb begin
      held_bcd_d = held_bcd_q;
      held_dp_d  = held_dp_q;
      pre_d      = pre_q + 1'b1;
      idx_d      = idx_q;

      // Last strobe wins: each load simply overwrites the holding registers.
      if (bus.load_i) begin
         held_bcd_d = bus.BCD_i;
         held_dp_d  = bus.dp_i;
      end

      // Scan runs free of enable/load; only reset repositions it.
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Leading-zero detection, walking from the most significant digit down.
   // A set decimal point stops the blanking run just like a non-zero nibble.
   // Digit 0 is never blanked, so bit 0 stays clear.
   always_comb begin
      blank_mask = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         zero_above    = zero_above & (held_bcd_q[4*k +: 4] == 4'd0) & ~held_dp_q[k];
         blank_mask[k] = zero_above;
      end
   end

   // Display next-state: outputs follow the current (pre-edge) digit index and
   // holding registers, which gives exactly one cycle of latency after an index
   // change or a capture.
   always_comb begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      nib   = held_bcd_q[4*int'(idx_q) +: 4];

      if (bus.enable_i && !(bus.blank_zeros_i && blank_mask[idx_q])) begin
         an_d[idx_q] = 1'b0;
         seg_d       = seg_code(nib);
         dp_d        = ~held_dp_q[idx_q];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         held_bcd_q <= '0;
         held_dp_q  <= '0;
         pre_q      <= '0;
         idx_q      <= '0;
         an_q       <= '1;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
      end else begin
         held_bcd_q <= held_bcd_d;
         held_dp_q  <= held_dp_d;
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign bus.an_o  = an_q;
   assign bus.seg_o = seg_q;
   assign bus.dp_o  = dp_q;

endmodule
